smc_pwm_core: RTL and testbench

Parametrised successor to the stepper-motor-controller register block. It keeps the same QSEL/QWRITE/QADDR register bus, but the registers now drive hardware. A shared period counter with prescaler feeds N_CH channel comparators, which generate PWM on the MNP/MNM coil pins. Duty, sign, mode and period are double-buffered and reload only at period boundaries, so an update never produces a glitched period.

---
 rtl/smc_pkg.sv | 32 +++
 rtl/smc_pwm_core_if.sv | 13 +
 rtl/smc_pwm_chan.sv | 73 +++++++
 rtl/smc_pwm_core.sv | 144 ++++++++++++++
 tb/tb_smc_pwm_core.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/smc_pkg.sv
// Shared constants and types for the stepper-motor PWM core: register map,
// channel mode encoding and MCCTL field positions.
package smc_pkg;

    localparam int MCPER     = 'h00;
    localparam int MCCTL     = 'h02;
    localparam int MCSTAT    = 'h04;
    localparam int MCCC_BASE = 'h10;
    localparam int MCDC_BASE = 'h20;

    localparam int CTL_EN     = 0;
    localparam int CTL_PRE_LO = 1;
    localparam int DC_SIGN    = 15;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        CENTER = 2'b11
    } mode_e;

    // Low PRE bits of the prescaler that must all be set for a tick.
    function automatic logic [2:0] pre_mask(input logic [1:0] pre);
        case (pre)
            2'd0:    pre_mask = 3'b000;
            2'd1:    pre_mask = 3'b001;
            2'd2:    pre_mask = 3'b011;
            default: pre_mask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/smc_pwm_core_if.sv
// Register bus of the PWM core: select, write strobe, address and data.
interface smc_pwm_core_if #(
    parameter int AW = 7
);
    logic          QSEL;
    logic          QWRITE;
    logic [AW-1:0] QADDR;
    logic [15:0]   QDATAIN;
    logic [15:0]   QDATAOUT;

    modport master (output QSEL, output QWRITE, output QADDR, output QDATAIN, input QDATAOUT);
    modport slave  (input QSEL, input QWRITE, input QADDR, input QDATAIN, output QDATAOUT);
endinterface

// File: rtl/smc_pwm_chan.sv
// One PWM channel: shadowed mode/sign/duty, comparator against the shared
// counter and registered coil outputs.
module smc_pwm_chan
    import smc_pkg::*;
#(
    parameter int CW = 11
) (
    input  logic          QCLK,
    input  logic          QRESET_N,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] per_s,
    input  logic          load,
    input  logic          en,
    input  logic [1:0]    mode_r,
    input  logic          sign_r,
    input  logic [CW-1:0] duty_r,
    output logic          mnp,
    output logic          mnm
);

    mode_e         mode_s;
    logic          sign_s;
    logic [CW-1:0] duty_s;
    logic [CW-1:0] d;
    logic [CW-1:0] lo;
    logic          pwm_p0;
    logic          mnp_p1;
    logic          mnm_p1;

    function automatic logic [CW-1:0] sat_duty(input logic [CW-1:0] duty, input logic [CW-1:0] per);
        sat_duty = (duty > per) ? per : duty;
    endfunction

    always_ff @(posedge QCLK or negedge QRESET_N) begin
        if (!QRESET_N) begin
            mode_s <= OFF;
            sign_s <= 1'b0;
            duty_s <= '0;
        end else if (load) begin
            mode_s <= mode_e'(mode_r);
            sign_s <= sign_r;
            duty_s <= duty_r;
        end
    end

    // p0: compare the live counter against the shadowed waveform
    always_comb begin
        d      = sat_duty(duty_s, per_s);
        lo     = (per_s - d) >> 1;
        pwm_p0 = 1'b0;
        case (mode_s)
            LEFT:    pwm_p0 = (cnt < d);
            RIGHT:   pwm_p0 = (cnt >= per_s - d);
            CENTER:  pwm_p0 = (cnt >= lo) && (cnt < lo + d);
            default: pwm_p0 = 1'b0;
        endcase
    end

    // p1: steer onto one coil pin and register
    always_ff @(posedge QCLK or negedge QRESET_N) begin
        if (!QRESET_N) begin
            mnp_p1 <= 1'b0;
            mnm_p1 <= 1'b0;
        end else begin
            mnp_p1 <= en && (per_s != '0) && pwm_p0 && !sign_s;
            mnm_p1 <= en && (per_s != '0) && pwm_p0 && sign_s;
        end
    end

    assign mnp = mnp_p1;
    assign mnm = mnm_p1;

endmodule

// File: rtl/smc_pwm_core.sv
// Stepper-motor PWM core: register file, read mux, prescaler, shared period
// counter and period flag driving N_CH channel comparators.
module smc_pwm_core
    import smc_pkg::*;
#(
    parameter int N_CH = 12,
    parameter int CW   = 11,
    parameter int AW   = 7
) (
    input  logic            QCLK,
    input  logic            QRESET_N,
    smc_pwm_core_if.slave   bus,
    output logic [N_CH-1:0] MNP,
    output logic [N_CH-1:0] MNM
);

    logic [CW-1:0]   mcper;
    logic            en;
    logic [1:0]      pre;
    logic            pf;
    logic [1:0]      mccc [N_CH];
    logic [CW-1:0]   mcdc_duty [N_CH];
    logic [N_CH-1:0] mcdc_sign;

    logic            wr, rd;
    int              addr_i;
    logic [15:0]     rd_data;
    logic            per_we, ctl_we, pf_clr;
    logic [N_CH-1:0] cc_we, dc_we;
    logic            unused_din;

    logic [2:0]      pre_cnt;
    logic            tick;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   per_s;
    logic            per_zero;
    logic            boundary;
    logic            load;

    assign wr         = bus.QSEL && bus.QWRITE;
    assign rd         = bus.QSEL && !bus.QWRITE;
    assign addr_i     = int'(bus.QADDR);
    assign unused_din = ^bus.QDATAIN;

    always_comb begin
        rd_data = '0;
        per_we  = 1'b0;
        ctl_we  = 1'b0;
        pf_clr  = 1'b0;
        cc_we   = '0;
        dc_we   = '0;
        if (addr_i == MCPER) begin
            rd_data = 16'(mcper);
            per_we  = wr;
        end else if (addr_i == MCCTL) begin
            rd_data = {13'b0, pre, en};
            ctl_we  = wr;
        end else if (addr_i == MCSTAT) begin
            rd_data = {15'b0, pf};
            pf_clr  = wr && bus.QDATAIN[0];
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            if (addr_i == MCCC_BASE + ch) begin
                rd_data   = {14'b0, mccc[ch]};
                cc_we[ch] = wr;
            end
            if (addr_i == MCDC_BASE + 2 * ch) begin
                rd_data          = 16'(mcdc_duty[ch]);
                rd_data[DC_SIGN] = mcdc_sign[ch];
                dc_we[ch]        = wr;
            end
        end
    end

    always_ff @(posedge QCLK or negedge QRESET_N) begin
        if (!QRESET_N) begin
            mcper        <= '0;
            en           <= 1'b0;
            pre          <= '0;
            mcdc_sign    <= '0;
            bus.QDATAOUT <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                mccc[ch]      <= '0;
                mcdc_duty[ch] <= '0;
            end
        end else begin
            if (per_we) mcper <= bus.QDATAIN[CW-1:0];
            if (ctl_we) begin
                en  <= bus.QDATAIN[CTL_EN];
                pre <= bus.QDATAIN[CTL_PRE_LO +: 2];
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                if (cc_we[ch]) mccc[ch] <= bus.QDATAIN[1:0];
                if (dc_we[ch]) begin
                    mcdc_duty[ch] <= bus.QDATAIN[CW-1:0];
                    mcdc_sign[ch] <= bus.QDATAIN[DC_SIGN];
                end
            end
            if (rd) bus.QDATAOUT <= rd_data;
        end
    end

    // Timebase: prescaler, period counter and boundary detection
    assign tick     = en && ((pre_cnt & pre_mask(pre)) == pre_mask(pre));
    assign per_zero = (per_s == '0);
    assign boundary = tick && !per_zero && (cnt == per_s - CW'(1));
    // A zero period never reaches a boundary, so shadows keep tracking the
    // registers until a non-zero MCPER arrives.
    assign load     = !en || per_zero || boundary;

    always_ff @(posedge QCLK or negedge QRESET_N) begin
        if (!QRESET_N) begin
            pre_cnt <= '0;
            cnt     <= '0;
            per_s   <= '0;
            pf      <= 1'b0;
        end else begin
            pre_cnt <= en ? pre_cnt + 3'd1 : 3'd0;
            if (!en || per_zero)  cnt <= '0;
            else if (boundary)    cnt <= '0;
            else if (tick)        cnt <= cnt + CW'(1);
            if (load)             per_s <= mcper;
            if (boundary)         pf <= 1'b1;
            else if (pf_clr)      pf <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        smc_pwm_chan #(.CW(CW)) u_chan (
            .QCLK     (QCLK),
            .QRESET_N (QRESET_N),
            .cnt      (cnt),
            .per_s    (per_s),
            .load     (load),
            .en       (en),
            .mode_r   (mccc[g]),
            .sign_r   (mcdc_sign[g]),
            .duty_r   (mcdc_duty[g]),
            .mnp      (MNP[g]),
            .mnm      (MNM[g])
        );
    end

endmodule

// File: tb/tb_smc_pwm_core.sv
// Directed bench for smc_pwm_core: PWM shapes, shadow reload, boundaries,
// period flag with prescaler, register masking and asynchronous reset.
module tb_smc_pwm_core;

    localparam int N_CH = 12;
    localparam int CW   = 11;
    localparam int AW   = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] mnp, mnm;
    logic            both_seen = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [N_CH-1:0] mnp_log [64];
    logic [N_CH-1:0] mnm_log [64];
    logic [15:0]     rdv;

    smc_pwm_core_if #(.AW(AW)) bus ();

    smc_pwm_core #(.N_CH(N_CH), .CW(CW), .AW(AW)) dut (
        .QCLK     (clk),
        .QRESET_N (rst_n),
        .bus      (bus),
        .MNP      (mnp),
        .MNM      (mnm)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (|(mnp & mnm)) both_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [15:0] d);
        bus.QSEL    = 1'b1;
        bus.QWRITE  = 1'b1;
        bus.QADDR   = a;
        bus.QDATAIN = d;
        @(negedge clk);
        bus.QSEL    = 1'b0;
        bus.QWRITE  = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [15:0] d);
        bus.QSEL   = 1'b1;
        bus.QWRITE = 1'b0;
        bus.QADDR  = a;
        @(negedge clk);
        d = bus.QDATAOUT;
        bus.QSEL   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mnp_log[i] = mnp;
            mnm_log[i] = mnm;
        end
    endtask

    // First captured sample ends up in the most significant position.
    function automatic logic [31:0] seq(input bit m, input int ch, input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = {s[30:0], m ? mnm_log[i][ch] : mnp_log[i][ch]};
        return s;
    endfunction

    function automatic logic [31:0] any_out(input int from_ch, input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++)
            s = s | 32'((mnp_log[i] >> from_ch) | (mnm_log[i] >> from_ch));
        return s;
    endfunction

    logic [AW-1:0] rst_addrs [7];

    initial begin
        rst_addrs   = '{7'h00, 7'h02, 7'h04, 7'h10, 7'h20, 7'h7F, 7'h1C};
        rst_n       = 1'b0;
        bus.QSEL    = 1'b0;
        bus.QWRITE  = 1'b0;
        bus.QADDR   = '0;
        bus.QDATAIN = '0;
        repeat (3) @(negedge clk);
        chk("rst_mnp", 32'(mnp), 32'h0);
        chk("rst_mnm", 32'(mnm), 32'h0);
        chk("rst_dout", 32'(bus.QDATAOUT), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(7'h00, rdv); chk("rst_mcper", 32'(rdv), 32'h0);

        // ch0 left d3, ch1 center negative d4, ch2 right d2, period 10
        bus_write(7'h00, 16'd10);
        bus_write(7'h10, 16'h0001);
        bus_write(7'h20, 16'h0003);
        bus_write(7'h11, 16'h0003);
        bus_write(7'h22, 16'h8004);
        bus_write(7'h12, 16'h0002);
        bus_write(7'h24, 16'h0002);
        bus_write(7'h02, 16'h0001);
        capture(20);
        chk("left_mnp0",   seq(0, 0, 20), 32'b1110000000_1110000000);
        chk("left_mnm0",   seq(1, 0, 20), 32'h0);
        chk("center_mnm1", seq(1, 1, 20), 32'b0001111000_0001111000);
        chk("center_mnp1", seq(0, 1, 20), 32'h0);
        chk("right_mnp2",  seq(0, 2, 20), 32'b0000000011_0000000011);
        chk("idle_chans",  any_out(3, 20), 32'h0);

        // duty change at cnt=5 only shows after the boundary
        bus_write(7'h02, 16'h0000);
        bus_write(7'h02, 16'h0001);
        fork
            capture(20);
            begin
                repeat (5) @(negedge clk);
                bus_write(7'h20, 16'h0007);
            end
        join
        chk("reload_mnp0", seq(0, 0, 20), 32'b1110000000_1111111000);
        bus_read(7'h20, rdv); chk("reload_rb", 32'(rdv), 32'h0007);

        bus_write(7'h02, 16'h0000);
        bus_write(7'h20, 16'h0000);
        bus_write(7'h02, 16'h0001);
        capture(20);
        chk("duty0_mnp0", seq(0, 0, 20), 32'h0);

        bus_write(7'h02, 16'h0000);
        bus_write(7'h20, 16'd15);
        bus_write(7'h02, 16'h0001);
        capture(20);
        chk("dutyfull_mnp0", seq(0, 0, 20), 32'h000F_FFFF);

        bus_write(7'h02, 16'h0000);
        bus_read(7'h04, rdv); chk("pf_set", 32'(rdv), 32'h1);
        bus_write(7'h04, 16'h0001);
        bus_read(7'h04, rdv); chk("pf_clr_idle", 32'(rdv), 32'h0);

        bus_write(7'h00, 16'h0000);
        bus_write(7'h02, 16'h0001);
        capture(20);
        chk("per0_outs", any_out(0, 20), 32'h0);
        bus_read(7'h04, rdv); chk("per0_pf", 32'(rdv), 32'h0);

        // PRE=2, period 4: first boundary ends cycle 15, second ends cycle 31
        bus_write(7'h02, 16'h0000);
        bus_write(7'h00, 16'd4);
        bus_write(7'h02, 16'h0005);
        repeat (15) @(negedge clk);
        bus_read(7'h04, rdv); chk("pf_c15", 32'(rdv), 32'h0);
        bus_read(7'h04, rdv); chk("pf_c16", 32'(rdv), 32'h1);
        bus_write(7'h04, 16'h0001);
        bus_read(7'h04, rdv); chk("pf_clr", 32'(rdv), 32'h0);
        repeat (11) @(negedge clk);
        bus_read(7'h04, rdv); chk("pf_c30", 32'(rdv), 32'h0);
        bus_write(7'h04, 16'h0001);
        bus_read(7'h04, rdv); chk("pf_set_wins", 32'(rdv), 32'h1);

        bus_write(7'h02, 16'h0000);
        bus_write(7'h00, 16'hFFFF);
        bus_read(7'h00, rdv); chk("mcper_mask", 32'(rdv), 32'h07FF);
        bus_write(7'h02, 16'hFFF8);
        bus_read(7'h02, rdv); chk("mcctl_mask", 32'(rdv), 32'h0000);
        bus_write(7'h1B, 16'hFFFE);
        bus_read(7'h1B, rdv); chk("mccc_last", 32'(rdv), 32'h0002);
        bus_read(7'h38, rdv); chk("mcdc_oob", 32'(rdv), 32'h0000);
        bus_write(7'h1C, 16'h0003);
        bus_read(7'h1C, rdv); chk("mccc_oob", 32'(rdv), 32'h0000);
        bus_write(7'h20, 16'hFFFF);
        bus_read(7'h20, rdv); chk("mcdc_mask", 32'(rdv), 32'h87FF);
        repeat (3) @(negedge clk);
        chk("dout_hold", 32'(bus.QDATAOUT), 32'h87FF);

        bus_write(7'h00, 16'd10);
        bus_write(7'h20, 16'd15);
        bus_write(7'h02, 16'h0001);
        repeat (4) @(negedge clk);
        chk("pre_rst_mnp0", 32'(mnp[0]), 32'h1);
        bus_read(7'h00, rdv); chk("mcper_rb", 32'(rdv), 32'd10);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_mnp", 32'(mnp), 32'h0);
        chk("arst_mnm", 32'(mnm), 32'h0);
        chk("arst_dout", 32'(bus.QDATAOUT), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus_read(rst_addrs[i], rdv);
            chk("post_rst_rd", 32'(rdv), 32'h0);
        end
        chk("post_rst_mnp", 32'(mnp), 32'h0);
        chk("excl", 32'(both_seen), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
